// File: rtl/dcache_arbiter.sv
// Two-lane (p0/p1) front end for the single dcache request/response port.
// Fixed priority to p0 with a p1 starvation escape; in-order ID FIFO steers responses.
module dcache_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [3:0]  p0_wstrb,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_uncached,
  output logic        p0_addr_ok,
  output logic        p0_data_ok,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [3:0]  p1_wstrb,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_uncached,
  output logic        p1_addr_ok,
  output logic        p1_data_ok,
  output logic [31:0] p1_rdata,

  output logic        dcache_req,
  output logic        dcache_wr,
  output logic [1:0]  dcache_size,
  output logic [3:0]  dcache_wstrb,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_wdata,
  output logic        dcache_uncached,
  input  logic        dcache_addr_ok,
  input  logic        dcache_data_ok,
  input  logic [31:0] dcache_rdata
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

  logic                       reset_q;
  logic [MAX_OUTSTANDING-1:0] id_mem;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic [3:0]                 starve_cnt;

  logic quiet;
  logic fifo_full;
  logic fifo_empty;
  logic grant_valid;
  logic grant_p1;
  logic accept;
  logic pop;
  logic head_id;

  // Handshakes stay silent while reset is high and for one cycle after it.
  assign quiet      = reset | reset_q;
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == {CW{1'b0}});

  always_comb begin
    grant_valid = 1'b0;
    grant_p1    = 1'b0;
    if (quiet || fifo_full) begin
      grant_valid = 1'b0;
      grant_p1    = 1'b0;
    end else if ((starve_cnt == STARVE_MAX) && p1_req) begin
      grant_valid = 1'b1;
      grant_p1    = 1'b1;
    end else if (p0_req) begin
      grant_valid = 1'b1;
      grant_p1    = 1'b0;
    end else if (p1_req) begin
      grant_valid = 1'b1;
      grant_p1    = 1'b1;
    end else begin
      grant_valid = 1'b0;
      grant_p1    = 1'b0;
    end
  end

  always_comb begin
    dcache_wr       = p0_we;
    dcache_size     = p0_size;
    dcache_wstrb    = p0_wstrb;
    dcache_addr     = p0_addr;
    dcache_wdata    = p0_wdata;
    dcache_uncached = p0_uncached;
    if (grant_p1) begin
      dcache_wr       = p1_we;
      dcache_size     = p1_size;
      dcache_wstrb    = p1_wstrb;
      dcache_addr     = p1_addr;
      dcache_wdata    = p1_wdata;
      dcache_uncached = p1_uncached;
    end else begin
      dcache_wr       = p0_we;
      dcache_size     = p0_size;
      dcache_wstrb    = p0_wstrb;
      dcache_addr     = p0_addr;
      dcache_wdata    = p0_wdata;
      dcache_uncached = p0_uncached;
    end
  end

  assign dcache_req = grant_valid;
  assign accept     = grant_valid & dcache_addr_ok;
  assign p0_addr_ok = accept & ~grant_p1;
  assign p1_addr_ok = accept & grant_p1;

  // An empty FIFO means the response has no owner; it is dropped.
  assign pop     = dcache_data_ok & ~fifo_empty & ~quiet;
  assign head_id = id_mem[rd_ptr];

  always_comb begin
    p0_data_ok = 1'b0;
    p1_data_ok = 1'b0;
    p0_rdata   = 32'h0000_0000;
    p1_rdata   = 32'h0000_0000;
    if (pop && head_id) begin
      p1_data_ok = 1'b1;
      p1_rdata   = dcache_rdata;
    end else if (pop) begin
      p0_data_ok = 1'b1;
      p0_rdata   = dcache_rdata;
    end else begin
      p0_data_ok = 1'b0;
      p1_data_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reset_q <= 1'b1;
    end else begin
      reset_q <= 1'b0;
    end
  end

  // Outstanding-ID FIFO: push on accept, pop on response; full blocks accept upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_mem <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (accept) begin
        id_mem[wr_ptr] <= grant_p1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!p1_req || p1_addr_ok) begin
      starve_cnt <= 4'd0;
    end else if (fifo_full || quiet) begin
      starve_cnt <= starve_cnt;
    end else if (starve_cnt < STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: responses are predicted into a queue at issue
// time and a negedge monitor pops and compares whenever a lane data_ok appears.
module tb_dcache_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_uncached, p1_req, p1_we, p1_uncached;
  logic [1:0]  p0_size, p1_size;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_addr_ok, p0_data_ok, p1_addr_ok, p1_data_ok;
  logic [31:0] p0_rdata, p1_rdata;
  logic        dcache_req, dcache_wr, dcache_uncached;
  logic [1:0]  dcache_size;
  logic [3:0]  dcache_wstrb;
  logic [31:0] dcache_addr, dcache_wdata;
  logic        dcache_addr_ok, dcache_data_ok;
  logic [31:0] dcache_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        lane;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  dcache_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_wstrb(p0_wstrb),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_uncached(p0_uncached),
    .p0_addr_ok(p0_addr_ok), .p0_data_ok(p0_data_ok), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_wstrb(p1_wstrb),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_uncached(p1_uncached),
    .p1_addr_ok(p1_addr_ok), .p1_data_ok(p1_data_ok), .p1_rdata(p1_rdata),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_size(dcache_size),
    .dcache_wstrb(dcache_wstrb), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_uncached(dcache_uncached), .dcache_addr_ok(dcache_addr_ok),
    .dcache_data_ok(dcache_data_ok), .dcache_rdata(dcache_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, predict the response if data_ok is driven, land on negedge.
  task automatic cyc(input logic r0, input logic r1, input logic dok,
                     input logic lane, input logic [31:0] rd);
    exp_t e;
    @(posedge clk); #1;
    p0_req = r0;
    p1_req = r1;
    dcache_data_ok = dok;
    dcache_rdata = rd;
    if (dok) begin
      e.lane = lane;
      e.data = rd;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Monitor: invariant and response routing against the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (p0_addr_ok && p1_addr_ok) begin
        errors++;
        $display("FAIL addr_ok_onehot: got p0=%b p1=%b expected at most one", p0_addr_ok, p1_addr_ok);
      end
      if (p0_data_ok || p1_data_ok) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_data_ok: got p0=%b p1=%b expected none", p0_data_ok, p1_data_ok);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ((p1_data_ok !== e.lane) || (p0_data_ok !== !e.lane) ||
              ((e.lane ? p1_rdata : p0_rdata) !== e.data) ||
              ((e.lane ? p0_rdata : p1_rdata) !== 32'h0)) begin
            errors++;
            $display("FAIL resp_route: got p0_ok=%b p1_ok=%b p0_rd=%h p1_rd=%h expected lane=%0d data=%h",
                     p0_data_ok, p1_data_ok, p0_rdata, p1_rdata, e.lane, e.data);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    p0_req = 1'b1; p1_req = 1'b0;
    p0_we = 1'b0; p1_we = 1'b0;
    p0_size = 2'd2; p1_size = 2'd1;
    p0_wstrb = 4'hF; p1_wstrb = 4'h3;
    p0_addr = 32'h0000_1000; p1_addr = 32'h0000_2000;
    p0_wdata = 32'h1111_1111; p1_wdata = 32'hCAFE_0001;
    p0_uncached = 1'b0; p1_uncached = 1'b1;
    dcache_addr_ok = 1'b1; dcache_data_ok = 1'b0; dcache_rdata = 32'h0;

    @(negedge clk);
    chk("rst_dcache_req", {31'd0, dcache_req}, 32'd0);
    chk("rst_p0_addr_ok", {31'd0, p0_addr_ok}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_dcache_req", {31'd0, dcache_req}, 32'd0);
    chk("post_rst_p0_addr_ok", {31'd0, p0_addr_ok}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Single lane load
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t1_p0_addr_ok", {31'd0, p0_addr_ok}, 32'd1);
    chk("t1_p1_addr_ok", {31'd0, p1_addr_ok}, 32'd0);
    chk("t1_dcache_req", {31'd0, dcache_req}, 32'd1);
    chk("t1_dcache_addr", dcache_addr, 32'h0000_1000);
    chk("t1_dcache_wr", {31'd0, dcache_wr}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t1_addr_ok_once", {31'd0, p0_addr_ok}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("t1_p1_data_ok", {31'd0, p1_data_ok}, 32'd0);
    chk("t1_p1_rdata", p1_rdata, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Contention: p0 first, then p1 (a write)
    p1_we = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_p0_first", {31'd0, p0_addr_ok}, 32'd1);
    chk("t2_p1_denied", {31'd0, p1_addr_ok}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_p1_second", {31'd0, p1_addr_ok}, 32'd1);
    chk("t2_addr", dcache_addr, 32'h0000_2000);
    chk("t2_wdata", dcache_wdata, 32'hCAFE_0001);
    chk("t2_wr", {31'd0, dcache_wr}, 32'd1);
    chk("t2_size_strb_unc", {25'd0, dcache_size, dcache_wstrb, dcache_uncached}, {25'd0, 2'd1, 4'h3, 1'b1});
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_000A);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_000B);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    p1_we = 1'b0;

    // Starvation escape after three denied cycles
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3_c0_p0", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h11);
    chk("t3_c1_p0", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h12);
    chk("t3_c2_p1_denied", {31'd0, p1_addr_ok}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h13);
    chk("t3_c3_p1_wins", {31'd0, p1_addr_ok}, 32'd1);
    chk("t3_c3_p0_denied", {31'd0, p0_addr_ok}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3_c4_p0_again", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h14);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h15);

    // FIFO full, no bypass, resume, drain across the pointer wrap
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_acc0", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_acc1", {31'd0, p1_addr_ok}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_acc2", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_acc3", {31'd0, p1_addr_ok}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_full_req", {31'd0, dcache_req}, 32'd0);
    chk("t4_full_addr_ok", {31'd0, p0_addr_ok}, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h31);
    chk("t4_no_full_bypass", {31'd0, p0_addr_ok}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_resume", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h32);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h33);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h34);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h35);

    // Same-cycle accept and pop at count 2; refill proves count held at 2
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h41);
    chk("t5_same_cycle_acc", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t5_acc3", {31'd0, p1_addr_ok}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5_acc4", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5_full", {31'd0, dcache_req}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h42);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h43);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h44);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h45);

    // Reset with three outstanding, then spurious responses
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    chk("t6_rst_data_ok", {30'd0, p0_data_ok, p1_data_ok}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'h55;
    @(negedge clk);
    chk("t6_spur_quiet", {30'd0, p0_data_ok, p1_data_ok}, 32'd0);
    @(posedge clk); #1;
    dcache_rdata = 32'h56;
    @(negedge clk);
    chk("t6_spur_empty", {30'd0, p0_data_ok, p1_data_ok}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_after_rst_acc", {31'd0, p0_addr_ok}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h66);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    chk("pending_responses", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_arbiter.md
Name: dcache_arbiter

Overview:
- Shares the single dcache request/response port between the two LSU lanes (lane a = p0, lane b = p1), so both memory pipes can issue loads and stores.
- Sits between the MMU's translated d1/d2 outputs and the dcache.
- Arbitrates address-phase requests using fixed priority with starvation escape.
- Tracks outstanding requests in an in-order ID FIFO and steers each dcache_data_ok and its rdata back to the lane that issued it.

Parameters:
- MAX_OUTSTANDING, 4, depth of the outstanding-ID FIFO. Must be a power of 2, at least 2.
- STARVE_LIMIT, 3, consecutive denied cycles of a requesting p1 after which p1 receives priority. Range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- p0_req / p1_req  input  1  lane request; held by the lane until its addr_ok
- p0_we / p1_we  input  1  write enable
- p0_size / p1_size  input  2  access size
- p0_wstrb / p1_wstrb  input  4  byte strobes
- p0_addr / p1_addr  input  32  physical address
- p0_wdata / p1_wdata  input  32  write data
- p0_uncached / p1_uncached  input  1  MAT is strongly ordered uncached
- p0_addr_ok / p1_addr_ok  output  1  request accepted this cycle
- p0_data_ok / p1_data_ok  output  1  response for that lane's oldest request
- p0_rdata / p1_rdata  output  32  read data, valid with data_ok
- dcache_req  output  1  forwarded request
- dcache_wr  output  1  forwarded write enable
- dcache_size  output  2  forwarded size
- dcache_wstrb  output  4  forwarded strobes
- dcache_addr  output  32  forwarded address
- dcache_wdata  output  32  forwarded write data
- dcache_uncached  output  1  forwarded uncached flag
- dcache_addr_ok  input  1  dcache accepts request
- dcache_data_ok  input  1  dcache response
- dcache_rdata  input  32  dcache read data

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset effects: FIFO emptied, starvation counter cleared. Outputs are 0 during reset and in the first cycle after: pX_addr_ok, pX_data_ok, dcache_req.
- Reset mid-operation discards all outstanding IDs. Later dcache_data_ok with an empty FIFO is dropped (no lane data_ok) and is a bench assertion failure.
- Grant (combinational, same cycle):
  - fifo_full forces no grant and dcache_req = 0.
  - Otherwise p1 wins if starve_cnt == STARVE_LIMIT and p1_req; else p0 wins if p0_req; else p1 wins if p1_req.
- The granted lane's fields drive all dcache_* outputs. With no grant the payload outputs carry the p0 fields, don't-care.
- dcache_req = granted lane's req.
- Accept = dcache_req && dcache_addr_ok. Only the granted lane sees pX_addr_ok = dcache_addr_ok; the other lane's addr_ok is 0.
- On accept, the grantee ID (0/1) is pushed to the FIFO.
- Response: each dcache_data_ok pops the FIFO head. p[head]_data_ok = 1 and p[head]_rdata = dcache_rdata in the same cycle. The non-selected rdata is 0.
- Writes also receive data_ok; rdata is don't-care for them.
- Ordering: responses return strictly in acceptance order across both lanes. Per-lane order follows from this.
- Same-cycle accept and data_ok: push and pop both occur and the count is unchanged.
  - If full at cycle start, accept is blocked (no full-bypass); only the pop happens.
  - If empty at cycle start, the pop is ignored (no empty-bypass, since dcache latency is at least 1).
- FIFO: rd/wr pointers of log2(MAX_OUTSTANDING) bits wrap naturally. count is log2(MAX_OUTSTANDING)+1 bits. full = count == MAX_OUTSTANDING.
- Starvation counter (4 bits):
  - +1 (saturating at STARVE_LIMIT) when p1_req && !p1_addr_ok && !fifo_full.
  - Cleared when p1_addr_ok or !p1_req.
  - Held while fifo_full.
- Invariant (asserted): p0_addr_ok && p1_addr_ok never both 1.

Test Plan:
- Single lane: p0 load to 0x1000 with dcache_addr_ok = 1, data_ok two cycles later with rdata = 0xDEADBEEF → p0_addr_ok pulses once; p0_data_ok with 0xDEADBEEF; p1 outputs stay 0.
- Contention: p0 and p1 both request with dcache_addr_ok held 1 → p0 accepted cycle 0; p1 accepted cycle 1. Responses 0xA then 0xB route to p0 then p1.
- Starvation: p0 requests every cycle (new request after each addr_ok), p1 continuous, STARVE_LIMIT = 3 → p1_addr_ok in the 4th cycle; counter returns to 0; p0 wins again next cycle.
- Full: MAX_OUTSTANDING = 4, four accepts with no data_ok → 5th cycle dcache_req = 0 and no addr_ok. One data_ok → next cycle accept resumes; FIFO order preserved across pointer wrap after 8+ transactions.
- Same cycle accept + data_ok with count = 2 → count stays 2; correct lane receives data_ok.
- Reset with 3 outstanding, then spurious dcache_data_ok → no pX_data_ok asserted; next request proceeds normally.
